cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Two-port arbiter that shares the single physical-memory line port between the instruction cache (read-only) and the data cache (read/write) of the pipelined RV32I core. It sits between the two L1 caches and the memory/L2 interface. It latches one granted request at a time, drives it downstream with stable address, data and command, and routes the single response back to the owner. On contention it alternates grants so neither side starves.

## Interface
Parameters:
- ADDR_W, 32, line-address width (byte address, low log2(LINE_W/8) bits are 0)
- LINE_W, 256, cache-line data width

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- i_read  in  1  I-cache line read request; held until i_resp
- i_addr  in  ADDR_W  I-cache line address
- i_rdata  out  LINE_W  line returned to I-cache, valid when i_resp=1
- i_resp  out  1  one-cycle completion pulse to I-cache
- d_read  in  1  D-cache line read request; held until d_resp
- d_write  in  1  D-cache line write-back request; held until d_resp
- d_addr  in  ADDR_W  D-cache line address
- d_wdata  in  LINE_W  D-cache write-back line
- d_rdata  out  LINE_W  line returned to D-cache, valid when d_resp=1
- d_resp  out  1  one-cycle completion pulse to D-cache
- mem_read  out  1  downstream read command, registered
- mem_write  out  1  downstream write command, registered
- mem_addr  out  ADDR_W  downstream address, registered
- mem_wdata  out  LINE_W  downstream write data, registered
- mem_rdata  in  LINE_W  downstream read data, valid with mem_resp
- mem_resp  in  1  downstream completion pulse

## Operation
- States: IDLE, BUSY_I, BUSY_D. A 1-bit last_grant register records the last owner (I or D).
- IDLE, only i_read: go to BUSY_I, latch i_addr, set mem_read=1, mem_write=0, last_grant=I.
- IDLE, only d_read or d_write: go to BUSY_D, latch d_addr and d_wdata, set mem_write=d_write, mem_read=~d_write, last_grant=D.
- IDLE, both sides requesting: grant the side that is not last_grant.
- d_read and d_write high together is illegal. The write wins and a write-back is issued.
- BUSY_x with mem_resp=1: x_resp=1 for that cycle. x_rdata=mem_rdata on that cycle. mem_read and mem_write clear. Next state is IDLE.
- BUSY_x with mem_resp=0: hold all mem_* outputs unchanged. The latched copy is used, so requester input changes have no effect on the downstream port.
- mem_resp while in IDLE: ignored. No resp pulse is generated.
- i_rdata and d_rdata are driven from mem_rdata at all times. Only the matching *_resp qualifies the data.
- The non-owner's resp is never asserted.
- A requester must drop its request in the cycle after its resp. Otherwise it is treated as a new request and granted again.

## Timing
- Reset (rst=0, async): state=IDLE, last_grant=I (first contention goes to D), mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, i_resp=0, d_resp=0.
- Grant latency: request sampled high in IDLE at edge t, then mem_read or mem_write is high from edge t (registered output, visible in cycle t+1 after sampling cycle t).
- Response is combinational: x_resp is asserted in the same cycle as mem_resp. There is zero added latency on return.
- Turnaround: after a response the arbiter spends at least one cycle in IDLE. The earliest next mem command follows that IDLE cycle.
- Minimum transaction: 1 IDLE cycle plus the downstream latency N, where N≥1 cycles in BUSY.
- Reset mid-transaction: outputs drop asynchronously. A mem_resp arriving after reset release is ignored because the state is IDLE.
- mem_* outputs are stable for the whole BUSY period. Downstream may sample them on any cycle.

## Test plan
- Single I read at 0x0000_0100, memory latency 3 → mem_read=1 with mem_addr=0x100 for 3 cycles, i_resp=1 for one cycle with i_rdata=mem_rdata, d_resp stays 0.
- D write-back at 0x8000_0040 with d_wdata=0xA5..A5 → mem_write=1, mem_read=0, mem_wdata=0xA5..A5 held until mem_resp, then d_resp pulses once.
- Simultaneous i_read and d_read, both held → D is granted first (last_grant=I after reset), then I after 1 IDLE cycle. Repeat the contention: grants alternate I, D, I.
- Requester changes d_addr from 0x40 to 0x80 mid-transaction → mem_addr stays 0x40 until mem_resp.
- Assert rst=0 during BUSY_D, then release and inject mem_resp → mem_read=mem_write=0 immediately, no d_resp, state IDLE.
- d_read=d_write=1 together → write issued (mem_write=1, mem_read=0). A spurious mem_resp in IDLE produces no resp pulse.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Shares one memory line port between the I-cache (read-only) and the D-cache (read/write).
// Grants one request at a time, holds the downstream command stable, and alternates grants on contention.
module cache_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t            state_q,      state_d;
  logic              last_grant_q, last_grant_d;
  logic              mem_read_q,   mem_read_d;
  logic              mem_write_q,  mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q,  mem_wdata_d;

  logic i_req;
  logic d_req;
  logic pick_d;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  // On contention the side that did not own the port last time wins.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    pick_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          pick_d = d_req && (!i_req || (last_grant_q == GRANT_I));
          if (pick_d) begin
            state_d      = BUSY_D;
            last_grant_d = GRANT_D;
            mem_addr_d   = d_addr;
            mem_wdata_d  = d_wdata;
            mem_write_d  = d_write;
            mem_read_d   = ~d_write;
          end else begin
            state_d      = BUSY_I;
            last_grant_d = GRANT_I;
            mem_addr_d   = i_addr;
            mem_write_d  = 1'b0;
            mem_read_d   = 1'b1;
          end
        end
      end

      BUSY_I, BUSY_D: begin
        if (mem_resp) begin
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end

      default: begin
        state_d     = IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // Responses pass straight through; only the owner's resp may fire.
  assign i_resp    = (state_q == BUSY_I) && mem_resp;
  assign d_resp    = (state_q == BUSY_D) && mem_resp;
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios plus randomized traffic,
// all compared every cycle against a transaction-level model of the arbiter.
module tb_cache_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  int errors = 0;
  int checks = 0;

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0b, want %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_addr(input string name, input logic [ADDR_W-1:0] act, input logic [ADDR_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_line(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Transaction-level model: at most one outstanding grant, remembered owner for fairness.
  bit                m_busy;
  bit                m_owner_d;
  bit                m_last_d;
  bit                m_is_write;
  bit                want_i;
  bit                want_d;
  logic [ADDR_W-1:0] m_addr;
  logic [LINE_W-1:0] m_wdata;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy     = 1'b0;
      m_owner_d  = 1'b0;
      m_last_d   = 1'b0;
      m_is_write = 1'b0;
      m_addr     = '0;
      m_wdata    = '0;
    end else if (m_busy) begin
      if (mem_resp) m_busy = 1'b0;
    end else begin
      want_i = i_read;
      want_d = d_read | d_write;
      if (want_i || want_d) begin
        m_owner_d = (want_i && want_d) ? !m_last_d : want_d;
        m_last_d  = m_owner_d;
        m_busy    = 1'b1;
        if (m_owner_d) begin
          m_addr     = d_addr;
          m_wdata    = d_wdata;
          m_is_write = d_write;
        end else begin
          m_addr     = i_addr;
          m_is_write = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    check_bit ("mem_read",  mem_read,  m_busy && !m_is_write);
    check_bit ("mem_write", mem_write, m_busy && m_is_write);
    check_addr("mem_addr",  mem_addr,  m_addr);
    check_line("mem_wdata", mem_wdata, m_wdata);
    check_bit ("i_resp",    i_resp,    m_busy && !m_owner_d && mem_resp);
    check_bit ("d_resp",    d_resp,    m_busy && m_owner_d && mem_resp);
    check_line("i_rdata",   i_rdata,   mem_rdata);
    check_line("d_rdata",   d_rdata,   mem_rdata);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  logic [LINE_W-1:0] pat;
  bit                i_got;
  bit                d_got;
  int                wait_cnt;
  int                kind;

  initial begin
    rst = 1'b0;
    i_read = 1'b0; i_addr = '0;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_resp = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    at_neg();
    check_bit ("rst_mem_read",  mem_read,  1'b0);
    check_bit ("rst_mem_write", mem_write, 1'b0);
    check_addr("rst_mem_addr",  mem_addr,  32'h0);
    check_line("rst_mem_wdata", mem_wdata, '0);
    check_bit ("rst_i_resp",    i_resp,    1'b0);
    check_bit ("rst_d_resp",    d_resp,    1'b0);
    #2 rst = 1'b1;
    step();

    // Single I read, memory latency 3
    i_addr = 32'h0000_0100;
    i_read = 1'b1;
    pat    = rand_line();
    step();
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin
        mem_rdata = pat;
        mem_resp  = 1'b1;
      end
      at_neg();
      check_bit ("ird_mem_read",  mem_read,  1'b1);
      check_bit ("ird_mem_write", mem_write, 1'b0);
      check_addr("ird_mem_addr",  mem_addr,  32'h0000_0100);
      check_bit ("ird_i_resp",    i_resp,    c == 2);
      check_bit ("ird_d_resp",    d_resp,    1'b0);
      if (c == 2) check_line("ird_i_rdata", i_rdata, pat);
      step();
    end
    mem_resp = 1'b0;
    i_read   = 1'b0;
    at_neg();
    check_bit("ird_done_mem_read", mem_read, 1'b0);
    check_bit("ird_done_i_resp",   i_resp,   1'b0);
    step();

    // D write-back; requester moves d_addr mid-transaction
    d_addr  = 32'h8000_0040;
    d_wdata = {32{8'hA5}};
    d_write = 1'b1;
    step();
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        d_addr  = 32'h8000_0080;
        d_wdata = '0;
      end
      if (c == 2) mem_resp = 1'b1;
      at_neg();
      check_bit ("dwr_mem_write", mem_write, 1'b1);
      check_bit ("dwr_mem_read",  mem_read,  1'b0);
      check_addr("dwr_mem_addr",  mem_addr,  32'h8000_0040);
      check_line("dwr_mem_wdata", mem_wdata, {32{8'hA5}});
      check_bit ("dwr_d_resp",    d_resp,    c == 2);
      check_bit ("dwr_i_resp",    i_resp,    1'b0);
      step();
    end
    mem_resp = 1'b0;
    d_write  = 1'b0;
    at_neg();
    check_bit("dwr_done_d_resp",    d_resp,    1'b0);
    check_bit("dwr_done_mem_write", mem_write, 1'b0);
    step();

    // Contention after a fresh reset: D, I, D, I
    rst = 1'b0;
    #2 rst = 1'b1;
    step();
    for (int g = 0; g < 4; g++) begin
      i_addr = 32'h0000_1000;
      d_addr = 32'h0000_2000;
      i_read = 1'b1;
      d_read = 1'b1;
      step();
      at_neg();
      check_bit ("arb_mem_read", mem_read, 1'b1);
      check_addr("arb_mem_addr", mem_addr, (g % 2 == 0) ? 32'h0000_2000 : 32'h0000_1000);
      step();
      mem_resp = 1'b1;
      at_neg();
      check_bit("arb_d_resp", d_resp, g % 2 == 0);
      check_bit("arb_i_resp", i_resp, g % 2 == 1);
      step();
      mem_resp = 1'b0;
      i_read   = 1'b0;
      d_read   = 1'b0;
      at_neg();
      check_bit("arb_idle_mem_read", mem_read, 1'b0);
      step();
    end

    // Reset asserted while BUSY_D, then a late mem_resp
    d_addr = 32'h0000_0040;
    d_read = 1'b1;
    step();
    at_neg();
    check_bit("rbusy_mem_read_before", mem_read, 1'b1);
    #2 rst = 1'b0;
    #1;
    check_bit ("rbusy_mem_read",  mem_read,  1'b0);
    check_bit ("rbusy_mem_write", mem_write, 1'b0);
    check_addr("rbusy_mem_addr",  mem_addr,  32'h0);
    d_read = 1'b0;
    #1 rst = 1'b1;
    step();
    mem_resp = 1'b1;
    at_neg();
    check_bit("rbusy_d_resp",   d_resp,   1'b0);
    check_bit("rbusy_i_resp",   i_resp,   1'b0);
    check_bit("rbusy_mem_read", mem_read, 1'b0);
    step();
    mem_resp = 1'b0;

    // Illegal read+write together: the write wins; then a spurious idle mem_resp
    d_addr  = 32'h0000_0300;
    d_wdata = rand_line();
    pat     = d_wdata;
    d_read  = 1'b1;
    d_write = 1'b1;
    step();
    at_neg();
    check_bit ("rw_mem_write", mem_write, 1'b1);
    check_bit ("rw_mem_read",  mem_read,  1'b0);
    check_addr("rw_mem_addr",  mem_addr,  32'h0000_0300);
    check_line("rw_mem_wdata", mem_wdata, pat);
    step();
    mem_resp = 1'b1;
    at_neg();
    check_bit("rw_d_resp", d_resp, 1'b1);
    step();
    mem_resp = 1'b0;
    d_read   = 1'b0;
    d_write  = 1'b0;
    step();
    mem_resp = 1'b1;
    at_neg();
    check_bit("spur_d_resp", d_resp, 1'b0);
    check_bit("spur_i_resp", i_resp, 1'b0);
    step();
    mem_resp = 1'b0;

    // Randomized traffic with a reactive memory and occasional resets
    wait_cnt = -1;
    for (int n = 0; n < 4000; n++) begin
      at_neg();
      i_got = i_resp;
      d_got = d_resp;
      step();
      mem_rdata = rand_line();
      if (mem_resp) begin
        mem_resp = 1'b0;
        wait_cnt = -1;
      end else if (mem_read || mem_write) begin
        if (wait_cnt < 0) wait_cnt = $urandom_range(0, 3);
        if (wait_cnt == 0) mem_resp = 1'b1;
        else wait_cnt--;
      end else begin
        wait_cnt = -1;
        mem_resp = ($urandom_range(0, 9) == 0);
      end

      if (i_got) begin
        i_read = 1'b0;
      end else if (!i_read && $urandom_range(0, 2) == 0) begin
        i_read = 1'b1;
        i_addr = $urandom & 32'hFFFF_FFE0;
      end

      if (d_got) begin
        d_read  = 1'b0;
        d_write = 1'b0;
      end else if (!(d_read || d_write)) begin
        if ($urandom_range(0, 2) == 0) begin
          kind    = $urandom_range(0, 9);
          d_write = (kind < 5);
          d_read  = (kind >= 4);
          d_addr  = $urandom & 32'hFFFF_FFE0;
          d_wdata = rand_line();
        end
      end else if ($urandom_range(0, 3) == 0) begin
        d_addr  = $urandom & 32'hFFFF_FFE0;
        d_wdata = rand_line();
      end

      if ($urandom_range(0, 299) == 0) begin
        #1 rst = 1'b0;
        #1 rst = 1'b1;
      end
    end

    at_neg();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
